// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, FSM states
// and the data-symbol decode used by the receive channel.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

    localparam logic ST_SEARCH_ENC = 1'b0;
    localparam logic ST_LOCKED_ENC = 1'b1;

    typedef enum logic {
        S_SEARCH = ST_SEARCH_ENC,
        S_LOCKED = ST_LOCKED_ENC
    } state_t;

    typedef struct packed {
        logic       is_ctrl;
        logic [1:0] c;
        logic [7:0] d;
    } sym_t;

    function automatic sym_t tmds_decode(input logic [9:0] q);
        sym_t       r;
        logic [7:0] qi;
        r.is_ctrl = 1'b1;
        r.c       = 2'b00;
        r.d       = 8'h00;
        case (q)
            CTRL_TOKEN_00: r.c = 2'b00;
            CTRL_TOKEN_01: r.c = 2'b01;
            CTRL_TOKEN_10: r.c = 2'b10;
            CTRL_TOKEN_11: r.c = 2'b11;
            default:       r.is_ctrl = 1'b0;
        endcase
        qi = q[9] ? ~q[7:0] : q[7:0];
        r.d[0] = qi[0];
        for (int i = 1; i < 8; i++) begin
            r.d[i] = q[8] ? (qi[i] ^ qi[i-1]) : ~(qi[i] ^ qi[i-1]);
        end
        return r;
    endfunction

    function automatic logic [3:0] next_offset(input logic [3:0] o);
        return (o == 4'd9) ? 4'd0 : o + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_channel_decoder_symbol.sv
// Combinational decode of one aligned 10-bit TMDS symbol
// into control flag, control bits and data byte.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] aligned,
    output logic       is_ctrl,
    output logic [1:0] c,
    output logic [7:0] d
);

    sym_t sym;

    // Pure lookup/XOR decode of the aligned symbol
    always_comb begin
        sym     = tmds_decode(aligned);
        is_ctrl = sym.is_ctrl;
        c       = sym.c;
        d       = sym.d;
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: word alignment by control-token
// runs, then symbol decode to pixel data or control bits.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int LOSS_TIMEOUT   = 4096,
    parameter int CNT_W          = 13
) (
    input  logic       pix_clk,
    input  logic       rst,
    input  logic [9:0] tmds_word,
    output logic [7:0] data_out,
    output logic [1:0] c_out,
    output logic       de_out,
    output logic       locked,
    output logic [3:0] bit_offset
);

    localparam int RUN_W = $clog2(CTRL_RUN + 1);

    logic [9:0]       r0;
    logic [9:0]       r1;
    logic [19:0]      shifted;
    logic [9:0]       aligned;
    logic             is_ctrl;
    logic [1:0]       sym_c;
    logic [7:0]       sym_d;

    state_t           state;
    state_t           state_nxt;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_nxt;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_nxt;
    logic [1:0]       prev_c;
    logic [1:0]       prev_nxt;
    logic [3:0]       off_nxt;
    logic [7:0]       data_nxt;
    logic [1:0]       c_nxt;
    logic             de_nxt;

    // r1 holds the older word, so the serial stream runs low-to-high
    assign shifted = {r0, r1} >> bit_offset;
    assign aligned = shifted[9:0];
    assign locked  = (state == S_LOCKED);

    tmds_symbol_decode u_dec (
        .aligned (aligned),
        .is_ctrl (is_ctrl),
        .c       (sym_c),
        .d       (sym_d)
    );

    // Alignment FSM, counters and next output values
    always_comb begin
        state_nxt = state;
        run_nxt   = run_cnt;
        tmo_nxt   = tmo_cnt;
        prev_nxt  = prev_c;
        off_nxt   = bit_offset;
        data_nxt  = 8'h00;
        c_nxt     = 2'b00;
        de_nxt    = 1'b0;

        if (state == S_LOCKED) begin
            if (is_ctrl) begin
                c_nxt = sym_c;
            end else begin
                de_nxt   = 1'b1;
                data_nxt = sym_d;
                c_nxt    = c_out;
            end
        end

        unique case (state)
            S_SEARCH: begin
                if (!is_ctrl) begin
                    run_nxt = '0;
                end else if (run_cnt != '0 && sym_c == prev_c) begin
                    run_nxt = run_cnt + 1'b1;
                end else begin
                    run_nxt = RUN_W'(1);
                end
                if (is_ctrl) begin
                    prev_nxt = sym_c;
                end
                tmo_nxt = tmo_cnt + 1'b1;
                if (run_nxt == RUN_W'(CTRL_RUN)) begin
                    state_nxt = S_LOCKED;
                    run_nxt   = '0;
                    tmo_nxt   = '0;
                end else if (tmo_cnt == CNT_W'(SEARCH_TIMEOUT - 1)) begin
                    off_nxt = next_offset(bit_offset);
                    run_nxt = '0;
                    tmo_nxt = '0;
                end
            end
            S_LOCKED: begin
                if (is_ctrl) begin
                    tmo_nxt = '0;
                end else if (tmo_cnt == CNT_W'(LOSS_TIMEOUT - 1)) begin
                    state_nxt = S_SEARCH;
                    off_nxt   = next_offset(bit_offset);
                    run_nxt   = '0;
                    tmo_nxt   = '0;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
        endcase
    end

    // Word window, FSM state and output registers
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            r0         <= '0;
            r1         <= '0;
            state      <= S_SEARCH;
            run_cnt    <= '0;
            tmo_cnt    <= '0;
            prev_c     <= '0;
            bit_offset <= '0;
            data_out   <= '0;
            c_out      <= '0;
            de_out     <= 1'b0;
        end else begin
            r0         <= tmds_word;
            r1         <= r0;
            state      <= state_nxt;
            run_cnt    <= run_nxt;
            tmo_cnt    <= tmo_nxt;
            prev_c     <= prev_nxt;
            bit_offset <= off_nxt;
            data_out   <= data_nxt;
            c_out      <= c_nxt;
            de_out     <= de_nxt;
        end
    end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder with a cycle
// model of the alignment/decode behaviour.
module tb_tmds_channel_decoder;

    localparam int TMO = 64;
    localparam int RUN = 8;

    logic       pix_clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] tmds_word = '0;
    logic [7:0] data_out;
    logic [1:0] c_out;
    logic       de_out;
    logic       locked;
    logic [3:0] bit_offset;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;
    int prev_sym = 0;

    int m_h0 = 0, m_h1 = 0, m_off = 0, m_run = 0, m_prev = 0;
    int m_tmo = 0, m_data = 0, m_c = 0, m_de = 0, m_lk = 0;
    int tokens[4] = '{'h354, 'h0AB, 'h154, 'h2AB};

    always #5 pix_clk = ~pix_clk;

    tmds_channel_decoder #(
        .CTRL_RUN       (RUN),
        .SEARCH_TIMEOUT (TMO),
        .LOSS_TIMEOUT   (TMO),
        .CNT_W          (13)
    ) dut (
        .pix_clk    (pix_clk),
        .rst        (rst),
        .tmds_word  (tmds_word),
        .data_out   (data_out),
        .c_out      (c_out),
        .de_out     (de_out),
        .locked     (locked),
        .bit_offset (bit_offset)
    );

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tok_index(int a);
        for (int i = 0; i < 4; i++)
            if (tokens[i] == a) return i;
        return -1;
    endfunction

    function automatic int data_decode(int q);
        int v, d, b;
        v = q;
        if ((q >> 9) & 1) v = v ^ 'hFF;
        d = v & 1;
        for (int i = 1; i < 8; i++) begin
            b = ((v >> i) ^ (v >> (i - 1))) & 1;
            if (((q >> 8) & 1) == 0) b = b ^ 1;
            d = d | (b << i);
        end
        return d;
    endfunction

    task automatic model_step();
        int a, t;
        if (rst) begin
            m_h0 = 0; m_h1 = 0; m_off = 0; m_run = 0; m_prev = 0;
            m_tmo = 0; m_data = 0; m_c = 0; m_de = 0; m_lk = 0;
            return;
        end
        a = (((m_h0 << 10) | m_h1) >> m_off) & 'h3FF;
        t = tok_index(a);
        if (m_lk == 0) begin
            m_de = 0; m_data = 0; m_c = 0;
        end else if (t >= 0) begin
            m_de = 0; m_data = 0; m_c = t;
        end else begin
            m_de = 1; m_data = data_decode(a);
        end
        if (m_lk == 0) begin
            if (t < 0) m_run = 0;
            else if (m_run > 0 && t == m_prev) m_run++;
            else m_run = 1;
            if (t >= 0) m_prev = t;
            if (m_run == RUN) begin
                m_lk = 1; m_run = 0; m_tmo = 0;
            end else if (m_tmo == TMO - 1) begin
                m_off = (m_off + 1) % 10; m_run = 0; m_tmo = 0;
            end else begin
                m_tmo++;
            end
        end else begin
            if (t >= 0) begin
                m_tmo = 0;
            end else if (m_tmo == TMO - 1) begin
                m_lk = 0; m_off = (m_off + 1) % 10; m_run = 0; m_tmo = 0;
            end else begin
                m_tmo++;
            end
        end
        m_h1 = m_h0;
        m_h0 = int'(tmds_word);
    endtask

    initial forever begin
        @(posedge pix_clk);
        model_step();
    end

    initial forever begin
        @(negedge pix_clk);
        if (chk_en) begin
            check("locked", int'(locked), m_lk);
            check("bit_offset", int'(bit_offset), m_off);
            check("de_out", int'(de_out), m_de);
            check("c_out", int'(c_out), m_c);
            check("data_out", int'(data_out), m_data);
        end
    end

    task automatic drive(int w, bit r);
        @(negedge pix_clk);
        rst = r;
        tmds_word = w[9:0];
    endtask

    task automatic sym(int s, int skew);
        int w;
        w = ((((s << 10) | prev_sym)) >> (10 - skew)) & 'h3FF;
        prev_sym = s;
        drive(w, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) drive(int'($urandom_range(0, 1023)), 1'b1);
        drive('h354, 1'b0);
        check("rst locked", int'(locked), 0);
        check("rst offset", int'(bit_offset), 0);
        check("rst data", int'(data_out), 0);
        check("rst c", int'(c_out), 0);
        check("rst de", int'(de_out), 0);
        chk_en = 1;

        for (int i = 0; i < 19; i++) drive('h354, 1'b0);
        check("lock0 locked", int'(locked), 1);
        check("lock0 offset", int'(bit_offset), 0);
        check("lock0 de", int'(de_out), 0);
        check("lock0 c", int'(c_out), 0);

        drive('h100, 1'b0);
        drive('h2FF, 1'b0);
        drive('h0AB, 1'b0);
        check("latency de early", int'(de_out), 0);
        drive('h0AB, 1'b0);
        check("d100 de", int'(de_out), 1);
        check("d100 data", int'(data_out), 'h00);
        drive('h0AB, 1'b0);
        check("d2FF data", int'(data_out), 'hFE);
        drive('h0AB, 1'b0);
        check("tok0AB de", int'(de_out), 0);
        check("tok0AB c", int'(c_out), 1);

        for (int i = 0; i < 60; i++) drive('h100, 1'b0);
        check("loss still locked", int'(locked), 1);
        for (int i = 0; i < 10; i++) drive('h100, 1'b0);
        check("loss locked", int'(locked), 0);
        check("loss offset", int'(bit_offset), 1);

        drive('h100, 1'b1);
        for (int k = 1; k <= 585; k++) drive('h100, 1'b0);
        check("wrap offset9", int'(bit_offset), 9);
        for (int k = 586; k <= 645; k++) drive('h100, 1'b0);
        check("wrap offset0", int'(bit_offset), 0);
        check("wrap locked", int'(locked), 0);

        drive('h154, 1'b1);
        prev_sym = 'h154;
        for (int k = 1; k <= 70; k++) sym('h154, 3);
        check("skew off1", int'(bit_offset), 1);
        for (int k = 71; k <= 134; k++) sym('h154, 3);
        check("skew off2", int'(bit_offset), 2);
        for (int k = 135; k <= 198; k++) sym('h154, 3);
        check("skew off3", int'(bit_offset), 3);
        for (int k = 199; k <= 230; k++) sym('h154, 3);
        check("skew locked", int'(locked), 1);
        check("skew off final", int'(bit_offset), 3);
        check("skew c", int'(c_out), 2);
        for (int k = 0; k < 4; k++) sym('h100, 3);
        check("skew d100 de", int'(de_out), 1);
        check("skew d100 data", int'(data_out), 0);
        for (int k = 0; k < 3; k++) sym('h100, 3);

        drive('h100, 1'b1);
        drive('h354, 1'b0);
        check("midrst locked", int'(locked), 0);
        check("midrst offset", int'(bit_offset), 0);
        check("midrst de", int'(de_out), 0);
        for (int k = 2; k <= 10; k++) drive('h354, 1'b0);
        check("relock early", int'(locked), 0);
        drive('h354, 1'b0);
        check("relock", int'(locked), 1);
        for (int k = 0; k < 5; k++) drive('h2AB, 1'b0);
        check("relock c11", int'(c_out), 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
